// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit owning Hi/Lo; 33-cycle latency start->done, start/loads ignored while busy.
// Divide support is compiled in only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_load,
  input  logic        lo_load,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] m_q, m_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [32:0] sum;
  logic [64:0] mul_step;
  logic [64:0] step;

  // Booth step: the add is done in 33 bits so a -2^31 multiplicand cannot overflow before the shift.
  always_comb begin
    sum = {acc_q[64], acc_q[64:33]};
    case (acc_q[1:0])
      2'b01:   sum = {acc_q[64], acc_q[64:33]} + {m_q[31], m_q};
      2'b10:   sum = {acc_q[64], acc_q[64:33]} - {m_q[31], m_q};
      default: sum = {acc_q[64], acc_q[64:33]};
    endcase
    mul_step = {sum, acc_q[32:1]};
  end

`ifdef MULT_DIV_DIVIDE_EN
  logic        op_q, op_d;
  logic        dz_q, dz_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;
  logic [64:0] div_step;

  assign a_mag = a[31] ? -a : a;
  assign b_mag = b[31] ? -b : b;

  // Restoring step: remainder in acc[64:33], quotient shifts in at acc[1].
  always_comb begin
    trial = acc_q[64:32] - {1'b0, m_q};
    if (trial[32]) div_step = {acc_q[63:32], acc_q[31:1], 1'b0, 1'b0};
    else           div_step = {trial[31:0], acc_q[31:1], 1'b1, 1'b0};
  end

  assign step     = op_q ? div_step : mul_step;
  assign div_zero = (state_q == FIN) && dz_q;
`else
  assign step     = mul_step;
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_DIV_DIVIDE_EN
    op_d      = op_q;
    dz_d      = 1'b0;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && op) begin
`ifdef MULT_DIV_DIVIDE_EN
          op_d      = 1'b1;
          neg_quo_d = a[31] ^ b[31];
          neg_rem_d = a[31];
          if (b == 32'd0) begin
            state_d = FIN;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = 5'd0;
            m_d     = b_mag;
            acc_d   = {32'd0, a_mag, 1'b0};
          end
`else
          state_d = FIN;
`endif
        end else if (start) begin
`ifdef MULT_DIV_DIVIDE_EN
          op_d = 1'b0;
`endif
          state_d = RUN;
          cnt_d   = 5'd0;
          m_d     = a;
          acc_d   = {32'd0, b, 1'b0};
        end else begin
          if (hi_load) hi_d = wdata;
          if (lo_load) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIN;
          hi_d    = step[64:33];
          lo_d    = step[32:1];
`ifdef MULT_DIV_DIVIDE_EN
          if (op_q) begin
            lo_d = neg_quo_q ? -step[32:1] : step[32:1];
            hi_d = neg_rem_q ? -step[64:33] : step[64:33];
          end
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      m_q     <= 32'd0;
      acc_q   <= 65'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MULT_DIV_DIVIDE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized/directed bench for mult_div_unit against an arithmetic reference model of Hi/Lo.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, op, hi_load, lo_load;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_load(hi_load), .lo_load(lo_load), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues one operation, scrambles the inputs afterwards, returns edges until done (-1 on timeout).
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    lat = 1;
    while (!done && lat < 100) begin tick(); lat++; end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    hi_load = 1'b0; lo_load = 1'b0; wdata = '0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b want=0", div_zero); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    m_hi = '0; m_lo = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    logic [31:0] xs [7] = '{32'h7, 32'h80000000, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] ys [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h7FFFFFFF};
    logic [63:0] p;
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 19; i++) begin
      if (i < 7) begin x = xs[i]; y = ys[i]; end
      else begin x = $urandom; y = $urandom; end
      p = model_mul(x, y);
      do_op(1'b0, x, y, lat);
      total++; if (lat != 33) begin bad++; $display("FAIL mul_latency a=%h b=%h got=%0d want=33", x, y, lat); end
      total++; if (hi !== p[63:32]) begin bad++; $display("FAIL mul_hi a=%h b=%h got=%h want=%h", x, y, hi, p[63:32]); end
      total++; if (lo !== p[31:0]) begin bad++; $display("FAIL mul_lo a=%h b=%h got=%h want=%h", x, y, lo, p[31:0]); end
      m_hi = p[63:32]; m_lo = p[31:0];
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul_after_done done=%0b busy=%0b want 0/0", done, busy); end
    end
  endtask

`ifdef MULT_DIV_DIVIDE_EN
  task automatic test_div();
    logic [31:0] xs [7] = '{32'hFFFFFFF9, 32'h80000000, 32'h7, 32'hFFFFFFF9, 32'h1, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] ys [7] = '{32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h1};
    logic [63:0] r;
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 19; i++) begin
      if (i < 7) begin x = xs[i]; y = ys[i]; end
      else begin
        x = $urandom;
        y = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        if ((i % 3) == 0) y = -y;
        if (y == 32'h0) y = 32'h3;
      end
      r = model_div(x, y);
      do_op(1'b1, x, y, lat);
      total++; if (lat != 33) begin bad++; $display("FAIL div_latency a=%h b=%h got=%0d want=33", x, y, lat); end
      total++; if (lo !== r[31:0]) begin bad++; $display("FAIL div_quo a=%h b=%h got=%h want=%h", x, y, lo, r[31:0]); end
      total++; if (hi !== r[63:32]) begin bad++; $display("FAIL div_rem a=%h b=%h got=%h want=%h", x, y, hi, r[63:32]); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_dz_spurious got=%0b want=0", div_zero); end
      m_hi = r[63:32]; m_lo = r[31:0];
      tick();
    end
  endtask
`else
  task automatic test_div_disabled();
    int lat;
    do_op(1'b1, 32'd17, 32'd5, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL divoff_latency got=%0d want=1", lat); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL divoff_hilo got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL divoff_dz got=%0b want=0", div_zero); end
    tick();
  endtask
`endif

  task automatic test_loads_div_zero();
    int lat;
    logic exp_dz;
`ifdef MULT_DIV_DIVIDE_EN
    exp_dz = 1'b1;
`else
    exp_dz = 1'b0;
`endif
    hi_load = 1'b1; lo_load = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    total++; if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin bad++; $display("FAIL load_both got=%h/%h want=cafef00d/cafef00d", hi, lo); end
    lo_load = 1'b0; wdata = 32'h1234;
    tick();
    hi_load = 1'b0; lo_load = 1'b1; wdata = 32'h5678;
    tick();
    lo_load = 1'b0;
    m_hi = 32'h1234; m_lo = 32'h5678;
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL load_single got=%h/%h want=1234/5678", hi, lo); end
    do_op(1'b1, 32'd5, 32'd0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
    total++; if (div_zero !== exp_dz) begin bad++; $display("FAIL dz_flag got=%0b want=%0b", div_zero, exp_dz); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dz_busy got=%0b want=1", busy); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL dz_hilo got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); end
    tick();
    total++; if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dz_after done=%0b dz=%0b busy=%0b want 0/0/0", done, div_zero, busy); end
  endtask

  task automatic test_load_start_conflict();
    logic [63:0] p;
    int lat;
    p = model_mul(32'd3, 32'd4);
    hi_load = 1'b1; lo_load = 1'b1; wdata = 32'hDEAD_BEEF;
    op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0; hi_load = 1'b0; lo_load = 1'b0;
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL conflict_load_dropped got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); end
    lat = 1;
    while (!done && lat < 100) begin tick(); lat++; end
    total++; if (!done || hi !== p[63:32] || lo !== p[31:0]) begin bad++; $display("FAIL conflict_result got=%h/%h want=%h/%h", hi, lo, p[63:32], p[31:0]); end
    m_hi = p[63:32]; m_lo = p[31:0];
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [63:0] p;
    int lat, extra;
    p = model_mul(32'h0001_2345, 32'hFFFF_0F0F);
    op = 1'b0; a = 32'h0001_2345; b = 32'hFFFF_0F0F; start = 1'b1;
    tick();
    start = 1'b0; lat = 1;
    repeat (4) begin tick(); lat++; end
    a = 32'd5; b = 32'd0; op = 1'b1; start = 1'b1; hi_load = 1'b1; wdata = 32'h0BAD_0BAD;
    tick(); lat++;
    start = 1'b0; hi_load = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL busy_start_ignored busy=%0b done=%0b want 1/0", busy, done); end
    total++; if (hi !== m_hi) begin bad++; $display("FAIL busy_load_ignored got=%h want=%h", hi, m_hi); end
    while (!done && lat < 100) begin tick(); lat++; end
    if (!done) lat = -1;
    total++; if (lat != 33) begin bad++; $display("FAIL busy_latency got=%0d want=33", lat); end
    total++; if (hi !== p[63:32] || lo !== p[31:0]) begin bad++; $display("FAIL busy_result got=%h/%h want=%h/%h", hi, lo, p[63:32], p[31:0]); end
    m_hi = p[63:32]; m_lo = p[31:0];
    extra = 0;
    repeat (40) begin tick(); if (done) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL busy_second_done got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    op = 1'b0; a = 32'hFFFF_FFF3; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rstmid_hilo got=%h/%h want=0/0", hi, lo); end
    m_hi = '0; m_lo = '0;
    tick(); tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin tick(); if (done) extra++; end
    total++; if (extra != 0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_done dones=%0d busy=%0b want 0/0", extra, busy); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL rstmid_hold got=%h/%h want=0/0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
`ifdef MULT_DIV_DIVIDE_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_loads_div_zero();
    test_load_start_conflict();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit holding the architectural Hi and Lo registers of the multicycle CPU. It sits beside the ALU and consumes the A and B register outputs. The control FSM starts it and waits for `done`. Its `hi`/`lo` outputs feed the write-source mux that selects register write-back data for MFHI/MFLO.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin the operation selected by `op`; sampled only in IDLE.
- `op` in 1: 0 = MULT (signed), 1 = DIV (signed).
- `a` in 32: rs operand (A register).
- `b` in 32: rt operand (B register).
- `hi_load` in 1: MTHI write enable; honoured only in IDLE.
- `lo_load` in 1: MTLO write enable; honoured only in IDLE.
- `wdata` in 32: data for `hi_load`/`lo_load`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: one-cycle pulse coincident with `done` when a DIV had `b == 0`.
- `hi` out 32: Hi register.
- `lo` out 32: Lo register.

## Operation
- States:
  - IDLE: accepts `start` and loads.
  - RUN: 32 iterations; a 5-bit counter runs 0..31.
  - DONE: one cycle; commits results and pulses `done`.
- Transitions:
  - IDLE→RUN when `start`, except a DIV with `b == 0`.
  - IDLE→DONE directly when `start` with DIV and `b == 0`.
  - RUN→DONE when the counter reaches 31.
  - DONE→IDLE unconditionally.
- Operands `a`/`b` are latched on the start edge. Later changes to the inputs have no effect.
- MULT:
  - Radix-2 Booth algorithm over a 65-bit accumulator.
  - The 64-bit signed product is committed as `hi` = [63:32], `lo` = [31:0].
- DIV:
  - Restoring division on operand magnitudes; signs are applied in DONE.
  - Quotient → `lo`, negated if `a[31]^b[31]`.
  - Remainder → `hi`, negated if `a[31]`. Truncating semantics: remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0 (wraps; no flag).
- Divide by zero: `hi`/`lo` unchanged; `div_zero` = 1 together with `done`.
- `start` while busy: ignored. No queueing.
- `hi_load`/`lo_load`:
  - In IDLE they write `wdata` on the next edge; both may be asserted together.
  - Ignored while busy.
  - If asserted in the same IDLE cycle as `start`, `start` wins and the loads are dropped.
- `hi`/`lo` hold their values until the next commit, load, or reset.

## Timing
- Reset (asynchronous, active-low): state = IDLE, counter = 0, `hi` = `lo` = 0, `busy` = `done` = `div_zero` = 0.
- Reset asserted mid-operation aborts it: no `done`, and Hi/Lo are cleared.
- Cycle numbering: edge E0 samples `start` in IDLE.
- Normal operation:
  - `busy` = 1 from after E0 until after E33.
  - RUN covers E1..E32.
  - After E32 the state is DONE: `done` = 1, and `hi`/`lo` already hold the new result (registered at E32).
  - After E33 the state is IDLE and `done` = 0.
  - Latency is 33 cycles from `start` to `done`.
- Divide by zero: DONE immediately after E0; `done` = `div_zero` = 1 for one cycle; `busy` = 1 for that cycle only.
- All outputs are registered; no combinational path from inputs to outputs.
- `done` is never asserted two cycles in a row.

## Configuration
- Macro: `MULT_DIV_DIVIDE_EN`.
- Defined: full DIV support as described above.
- Undefined:
  - Divider datapath and sign-correction logic are compiled out.
  - `start` with `op` = 1 goes IDLE→DONE and pulses `done` with `hi`/`lo` unchanged.
  - `div_zero` is tied to 0.
  - MULT and the loads are unaffected.

## Test plan
- MULT `a` = 7, `b` = 0xFFFFFFFD (−3) → `done` exactly 33 cycles after `start`; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- MULT `a` = `b` = 0x80000000 → `hi` = 0x40000000, `lo` = 0x00000000.
- DIV `a` = 0xFFFFFFF9 (−7), `b` = 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- Set `hi` = 0x1234 and `lo` = 0x5678 via loads, then DIV 5/0 → `done` and `div_zero` high in the cycle after `start`; `hi`/`lo` stay 0x1234/0x5678.
- Change `a`/`b` and pulse `start` (op = DIV) at cycle 5 of a running MULT, and assert `hi_load` during RUN → original MULT result unaffected, no second `done`, Hi unchanged by the load.
- Assert `reset` low at cycle 10 of a MULT → `busy` = 0, `hi` = `lo` = 0 immediately; no `done` follows.
